// File: rtl/param_lifo_stack.sv
// param_lifo_stack: parametrised LIFO with peek, registered pop, replace-top and sticky error flags
module param_lifo_stack #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic              clr_err,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [DATA_W-1:0] top_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0] top_idx, count_nxt;
  logic [AW-1:0] top_ptr, wr_ptr;
  logic do_push, do_pop, replace, bypass, wr_en;
  always_comb begin
    empty     = count == '0;
    full      = count == CNT_W'(DEPTH);
    top_idx   = count - 1'b1;
    top_ptr   = top_idx[AW-1:0];
    top_data  = empty ? '0 : mem[top_ptr];
    do_push   = push & ~pop & ~full;
    do_pop    = pop & ~push & ~empty;
    replace   = push & pop & ~empty;
    bypass    = push & pop & empty;
    wr_en     = rst_n & (do_push | replace);
    wr_ptr    = replace ? top_ptr : count[AW-1:0];
    count_nxt = do_push ? count + 1'b1 : do_pop ? top_idx : count;
  end
  // storage is deliberately not reset so it can map onto plain RAM
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk)
    if (!rst_n) begin
      count     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      pop_valid <= do_pop | replace | bypass;
      pop_data  <= (do_pop | replace) ? mem[top_ptr] : bypass ? push_data : pop_data;
      overflow  <= (push & ~pop & full) | (overflow & ~clr_err);
      underflow <= (pop & ~push & empty) | (underflow & ~clr_err);
    end
endmodule
